lsu_bus: RTL and testbench



---
 rtl/lsu_bus_pkg.sv | 31 +++
 rtl/lsu_align.sv | 47 ++++
 rtl/lsu_bus.sv | 128 ++++++++++++
 tb/tb_lsu_bus.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_bus_pkg.sv
// Shared definitions for the load/store unit: FSM states, load/store
// operation codes, byte-mask encodings and the alignment rule.
package lsu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] OPR_LB  = 3'b000;
    localparam logic [2:0] OPR_LH  = 3'b001;
    localparam logic [2:0] OPR_LW  = 3'b010;
    localparam logic [2:0] OPR_LBU = 3'b100;
    localparam logic [2:0] OPR_LHU = 3'b101;

    localparam logic [3:0] OPW_BYTE = 4'b0001;
    localparam logic [3:0] OPW_HALF = 4'b0011;
    localparam logic [3:0] OPW_WORD = 4'b1111;

    // Halves need an even address, words a 4-byte boundary; bytes always fit.
    function automatic logic is_aligned(input logic [3:0] opw, input logic [1:0] lo);
        case (opw)
            OPW_HALF: return ~lo[0];
            OPW_WORD: return (lo == 2'b00);
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit: store byte enables and data
// replication, plus load lane selection with sign/zero extension.
module lsu_align
    import lsu_bus_pkg::*;
(
    input  logic [3:0]  st_opw,
    input  logic [1:0]  st_lo,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_opr,
    input  logic [1:0]  ld_lo,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]         lane_b;
    logic [15:0]        lane_h;
    logic signed [31:0] sext_b;
    logic signed [31:0] sext_h;

    always_comb begin
        st_be = st_opw << st_lo;
        case (st_opw)
            OPW_BYTE: st_wdata = {4{st_data[7:0]}};
            OPW_HALF: st_wdata = {2{st_data[15:0]}};
            default:  st_wdata = st_data;
        endcase
    end

    assign lane_b = ld_word[{ld_lo, 3'b000} +: 8];
    assign lane_h = ld_lo[1] ? ld_word[31:16] : ld_word[15:0];
    assign sext_b = 32'(signed'(lane_b));
    assign sext_h = 32'(signed'(lane_h));

    always_comb begin
        case (ld_opr)
            OPR_LB:  ld_data = sext_b;
            OPR_LH:  ld_data = sext_h;
            OPR_LBU: ld_data = {24'h0, lane_b};
            OPR_LHU: ld_data = {16'h0, lane_h};
            OPR_LW:  ld_data = ld_word;
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/lsu_bus.sv
// Load/store unit: runs one req/gnt/rvalid bus transaction per aligned
// load or store, stalling the core until the response has been returned.
module lsu_bus
    import lsu_bus_pkg::*;
#(
    parameter int                 ADDR_W         = 32,
    parameter logic [ADDR_W-1:0]  RESET_ADDR_DRV = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        req_opr,
    input  logic [3:0]        req_opw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic [31:0]       rdata_out,
    output logic              rdata_valid,
    output logic              misalign,
    output logic              err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_err
);

    state_t      state, state_next;
    logic        aligned;
    logic        resp;
    logic [2:0]  opr_p1;
    logic [1:0]  lo_p1;
    logic        we_p1;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;

    assign aligned = is_aligned(req_opw, req_addr[1:0]);
    assign stall   = req_valid & (state != DONE) & aligned;
    // A response only counts once the request has been granted.
    assign resp    = (((state == REQ) & bus_gnt) | (state == WAIT)) & bus_rvalid;

    lsu_align u_align (
        .st_opw   (req_opw),
        .st_lo    (req_addr[1:0]),
        .st_data  (req_wdata),
        .st_be    (st_be),
        .st_wdata (st_wdata),
        .ld_opr   (opr_p1),
        .ld_lo    (lo_p1),
        .ld_word  (bus_rdata),
        .ld_data  (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req_valid && aligned) state_next = REQ;
            REQ:  if (bus_gnt) state_next = bus_rvalid ? DONE : WAIT;
            WAIT: if (bus_rvalid) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered bus drive and response capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= RESET_ADDR_DRV;
            bus_be      <= 4'h0;
            bus_wdata   <= 32'h0;
            rdata_out   <= 32'h0;
            rdata_valid <= 1'b0;
            misalign    <= 1'b0;
            err         <= 1'b0;
            opr_p1      <= 3'h0;
            lo_p1       <= 2'h0;
            we_p1       <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            misalign    <= 1'b0;
            err         <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && aligned) begin
                        opr_p1    <= req_opr;
                        lo_p1     <= req_addr[1:0];
                        we_p1     <= req_we;
                        bus_req   <= 1'b1;
                        bus_we    <= req_we;
                        bus_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                        bus_be    <= st_be;
                        bus_wdata <= st_wdata;
                    end else if (req_valid) begin
                        misalign  <= 1'b1;
                        rdata_out <= 32'h0;
                    end
                end
                REQ: if (bus_gnt) bus_req <= 1'b0;
                DONE: begin
                    bus_we    <= 1'b0;
                    bus_be    <= 4'h0;
                    bus_wdata <= 32'h0;
                    bus_addr  <= RESET_ADDR_DRV;
                end
                default: ;
            endcase
            if (resp) begin
                rdata_out   <= (we_p1 | bus_err) ? 32'h0 : ld_data;
                rdata_valid <= ~we_p1;
                err         <= bus_err;
            end
        end
    end

endmodule

// File: tb/tb_lsu_bus.sv
// Scoreboard bench for lsu_bus: directed loads/stores with hand-computed
// bus and response expectations, checked by free-running monitors.
module tb_lsu_bus;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we;
    logic [2:0]  req_opr;
    logic [3:0]  req_opw;
    logic [31:0] req_addr, req_wdata;
    logic        stall;
    logic [31:0] rdata_out;
    logic        rdata_valid, misalign, err;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt, bus_rvalid, bus_err;
    logic [31:0] bus_rdata;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    typedef struct packed {
        logic [31:0] data;
        logic        valid;
        logic        mis;
        logic        err;
    } resp_t;

    bus_t  bus_q[$];
    resp_t resp_q[$];
    int    checks = 0;
    int    errors = 0;

    lsu_bus #(.ADDR_W(32), .RESET_ADDR_DRV(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_opr(req_opr),
        .req_opw(req_opw), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rdata_out(rdata_out), .rdata_valid(rdata_valid),
        .misalign(misalign), .err(err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus monitor: outputs must match the queued transaction every cycle bus_req is up.
    initial forever begin
        @(negedge clk);
        #2;
        if (rst_n && bus_req) begin
            if (bus_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL bus_unexpected: got addr %h be %b, expected no request", bus_addr, bus_be);
            end else begin
                check("bus_fields", {bus_addr, bus_we, bus_be, bus_wdata}, bus_q[0]);
                if (bus_gnt) void'(bus_q.pop_front());
            end
        end
    end

    // Response monitor
    initial forever begin
        @(negedge clk);
        #2;
        if (rst_n && (rdata_valid || misalign || err)) begin
            if (resp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected: got data %h v%b m%b e%b, expected none",
                         rdata_out, rdata_valid, misalign, err);
            end else begin
                check("response", {rdata_out, rdata_valid, misalign, err}, resp_q.pop_front());
            end
        end
    end

    task automatic access(input logic we, input logic [2:0] opr, input logic [3:0] opw,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int gdly, input int rdly,
                          input logic berr, input logic emis, input logic [31:0] eaddr,
                          input logic [3:0] ebe, input logic [31:0] ewdata,
                          input logic [31:0] erdata, input int estall);
        int sc = 0;
        int rc = 0;
        int wc = 0;
        bit granted = 0;
        bit done = 0;
        if (!emis) bus_q.push_back('{addr: eaddr, we: we, be: ebe, wdata: ewdata});
        if (emis || !we || berr)
            resp_q.push_back('{data: erdata, valid: !we && !emis, mis: emis, err: berr});
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_we = we; req_opr = opr; req_opw = opw;
        req_addr = addr; req_wdata = wdata;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
            if (!stall) begin
                done = 1;
            end else begin
                sc++;
                if (!granted && bus_req) begin
                    if (rc == gdly) begin
                        bus_gnt = 1'b1;
                        granted = 1;
                        if (rdly == 0) begin
                            bus_rvalid = 1'b1; bus_err = berr; bus_rdata = rdata;
                        end else begin
                            wc = rdly;
                        end
                    end
                    rc++;
                end else if (granted && wc > 0) begin
                    wc--;
                    if (wc == 0) begin
                        bus_rvalid = 1'b1; bus_err = berr; bus_rdata = rdata;
                    end
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL access_timeout: stall still %b after 60 cycles, required 0", stall);
        end
        check("stall_cycles", 96'(sc), 96'(estall));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_opr = 3'h0; req_opw = 4'h0;
        req_addr = 32'h0; req_wdata = 32'h0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
        repeat (2) @(negedge clk);
        check("reset_bus", {bus_req, bus_we, bus_addr, bus_be, bus_wdata}, 96'h0);
        check("reset_resp", {rdata_out, rdata_valid, misalign, err, stall}, 96'h0);
        rst_n = 1'b1;

        // we  opr     opw      addr          wdata         rdata   gdly rdly berr mis eaddr         be       ewdata        erdata        stall
        access(0, 3'b010, 4'b1111, 32'h104, 32'h0,        32'hDEADBEEF, 0, 1, 0, 0, 32'h104, 4'b1111, 32'h0,        32'hDEADBEEF, 3);
        access(0, 3'b000, 4'b0001, 32'h203, 32'h000000A5, 32'h80112233, 0, 1, 0, 0, 32'h200, 4'b1000, 32'hA5A5A5A5, 32'hFFFFFF80, 3);
        access(0, 3'b100, 4'b0001, 32'h203, 32'h000000A5, 32'h80112233, 0, 1, 0, 0, 32'h200, 4'b1000, 32'hA5A5A5A5, 32'h00000080, 3);
        access(1, 3'b001, 4'b0011, 32'h012, 32'h0000ABCD, 32'h0,        0, 1, 0, 0, 32'h010, 4'b1100, 32'hABCDABCD, 32'h0,        3);
        access(0, 3'b010, 4'b1111, 32'h101, 32'h0,        32'h0,        0, 1, 0, 1, 32'h0,   4'b0000, 32'h0,        32'h0,        0);
        access(0, 3'b101, 4'b0011, 32'h040, 32'h12345678, 32'hFFFF1234, 0, 1, 1, 0, 32'h040, 4'b0011, 32'h56785678, 32'h0,        3);
        access(0, 3'b010, 4'b1111, 32'h088, 32'h11111111, 32'h0BADF00D, 5, 0, 0, 0, 32'h088, 4'b1111, 32'h11111111, 32'h0BADF00D, 7);
        access(0, 3'b001, 4'b0011, 32'h206, 32'h00007777, 32'h9ABC1234, 0, 1, 0, 0, 32'h204, 4'b1100, 32'h77777777, 32'hFFFF9ABC, 3);
        access(0, 3'b101, 4'b0011, 32'h206, 32'h00007777, 32'h9ABC1234, 0, 1, 0, 0, 32'h204, 4'b1100, 32'h77777777, 32'h00009ABC, 3);
        access(1, 3'b000, 4'b0001, 32'h007, 32'h0000005A, 32'h0,        0, 1, 0, 0, 32'h004, 4'b1000, 32'h5A5A5A5A, 32'h0,        3);
        access(1, 3'b001, 4'b0011, 32'h013, 32'h0000ABCD, 32'h0,        0, 1, 0, 1, 32'h0,   4'b0000, 32'h0,        32'h0,        0);

        // Reset in the middle of a load, then a late response that must be ignored.
        bus_q.push_back('{addr: 32'h300, we: 1'b0, be: 4'b1111, wdata: 32'h0});
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_we = 1'b0; req_opr = 3'b010; req_opw = 4'b1111;
        req_addr = 32'h300; req_wdata = 32'h0;
        begin
            bit seen = 0;
            for (int i = 0; i < 10 && !seen; i++) begin
                @(negedge clk);
                if (bus_req) seen = 1;
            end
            if (!seen) begin
                checks++;
                errors++;
                $display("FAIL reset_seq_req: bus_req never rose, required 1");
            end
        end
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        check("wait_stall", 96'(stall), 96'h1);
        #1;
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        check("async_reset_bus", {bus_req, bus_addr, bus_be}, 96'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_rvalid = 1'b1; bus_rdata = 32'h55AA55AA;
        @(negedge clk);
        bus_rvalid = 1'b0;
        check("late_rvalid_ignored", {bus_req, stall, rdata_valid, rdata_out}, 96'h0);

        access(1, 3'b010, 4'b1111, 32'h008, 32'hCAFEF00D, 32'h0,        0, 3, 0, 0, 32'h008, 4'b1111, 32'hCAFEF00D, 32'h0,        5);

        repeat (3) @(negedge clk);
        check("bus_queue_drained", 96'(bus_q.size()), 96'h0);
        check("resp_queue_drained", 96'(resp_q.size()), 96'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
